// File: rtl/uart_frame_parser.sv
// Frame parser behind a UART byte receiver: A5 5A | CMD | LEN | payload | CHK, payload streamed
// out after checksum pass. Define UART_FRAME_TIMEOUT_EN to enable the inter-byte gap timeout.
module uart_frame_parser #(
    parameter int unsigned MAX_LEN     = 16,
    parameter int unsigned TIMEOUT_CYC = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rx_data,
    input  logic       rx_done,
    output logic       frm_start,
    output logic [7:0] frm_cmd,
    output logic [7:0] frm_len,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_last,
    output logic       frm_err,
    output logic [1:0] err_code,
    output logic       rx_drop
);

    localparam int unsigned IdxW    = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [7:0]  MaxLen8 = 8'(MAX_LEN);

    if (MAX_LEN < 1 || MAX_LEN > 255 || TIMEOUT_CYC < 1) begin : g_bad_param
        $error("uart_frame_parser: MAX_LEN must be 1..255 and TIMEOUT_CYC >= 1");
    end

    typedef enum logic [2:0] {
        StIdle, StHdr2, StCmd, StLen, StPay, StChk, StDrain
    } state_e;

    state_e     state_q, state_d;
    logic [7:0] sum_q, sum_d;
    logic [7:0] cmd_q, cmd_d;
    logic [7:0] len_q, len_d;
    logic [7:0] idx_q, idx_d;
    logic [7:0] rd_idx_q, rd_idx_d;
    logic [7:0] frm_cmd_q, frm_cmd_d;
    logic [7:0] frm_len_q, frm_len_d;
    logic [1:0] err_code_q, err_code_d;
    logic       frm_start_q, frm_start_d;
    logic       frm_err_q, frm_err_d;
    logic       rx_drop_q, rx_drop_d;
    logic       pay_we;
    logic [7:0] pay_q [MAX_LEN];

`ifdef UART_FRAME_TIMEOUT_EN
    localparam int unsigned GapW = $clog2(TIMEOUT_CYC + 1);
    logic [GapW-1:0] gap_q, gap_d;
`endif

    always_comb begin
        state_d     = state_q;
        sum_d       = sum_q;
        cmd_d       = cmd_q;
        len_d       = len_q;
        idx_d       = idx_q;
        rd_idx_d    = rd_idx_q;
        frm_cmd_d   = frm_cmd_q;
        frm_len_d   = frm_len_q;
        err_code_d  = err_code_q;
        frm_start_d = 1'b0;
        frm_err_d   = 1'b0;
        rx_drop_d   = 1'b0;
        pay_we      = 1'b0;
        unique case (state_q)
            StIdle: if (rx_done && rx_data == 8'hA5) state_d = StHdr2;
            StHdr2: if (rx_done) begin
                if (rx_data == 8'h5A)      state_d = StCmd;
                else if (rx_data == 8'hA5) state_d = StHdr2;
                else                       state_d = StIdle;
            end
            StCmd: if (rx_done) begin
                cmd_d   = rx_data;
                sum_d   = rx_data;
                state_d = StLen;
            end
            StLen: if (rx_done) begin
                if (rx_data > MaxLen8) begin
                    frm_err_d  = 1'b1;
                    err_code_d = 2'd1;
                    state_d    = StIdle;
                end else begin
                    sum_d   = sum_q + rx_data;
                    len_d   = rx_data;
                    idx_d   = 8'd0;
                    state_d = (rx_data == 8'd0) ? StChk : StPay;
                end
            end
            StPay: if (rx_done) begin
                pay_we = 1'b1;
                sum_d  = sum_q + rx_data;
                idx_d  = idx_q + 8'd1;
                if (idx_q == len_q - 8'd1) state_d = StChk;
            end
            StChk: if (rx_done) begin
                if (rx_data == sum_q) begin
                    frm_start_d = 1'b1;
                    frm_cmd_d   = cmd_q;
                    frm_len_d   = len_q;
                    rd_idx_d    = 8'd0;
                    state_d     = (len_q == 8'd0) ? StIdle : StDrain;
                end else begin
                    frm_err_d  = 1'b1;
                    err_code_d = 2'd2;
                    state_d    = StIdle;
                end
            end
            StDrain: begin
                rx_drop_d = rx_done;
                if (out_ready) begin
                    if (rd_idx_q == frm_len_q - 8'd1) state_d = StIdle;
                    else                              rd_idx_d = rd_idx_q + 8'd1;
                end
            end
            default: state_d = StIdle;
        endcase
`ifdef UART_FRAME_TIMEOUT_EN
        // Gap counter only runs while a frame is partially received.
        gap_d = gap_q;
        if (rx_done || state_q == StIdle || state_q == StDrain) begin
            gap_d = '0;
        end else if (gap_q == GapW'(TIMEOUT_CYC - 1)) begin
            gap_d      = '0;
            frm_err_d  = 1'b1;
            err_code_d = 2'd3;
            state_d    = StIdle;
        end else begin
            gap_d = gap_q + 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            sum_q       <= 8'd0;
            cmd_q       <= 8'd0;
            len_q       <= 8'd0;
            idx_q       <= 8'd0;
            rd_idx_q    <= 8'd0;
            frm_cmd_q   <= 8'd0;
            frm_len_q   <= 8'd0;
            err_code_q  <= 2'd0;
            frm_start_q <= 1'b0;
            frm_err_q   <= 1'b0;
            rx_drop_q   <= 1'b0;
`ifdef UART_FRAME_TIMEOUT_EN
            gap_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            sum_q       <= sum_d;
            cmd_q       <= cmd_d;
            len_q       <= len_d;
            idx_q       <= idx_d;
            rd_idx_q    <= rd_idx_d;
            frm_cmd_q   <= frm_cmd_d;
            frm_len_q   <= frm_len_d;
            err_code_q  <= err_code_d;
            frm_start_q <= frm_start_d;
            frm_err_q   <= frm_err_d;
            rx_drop_q   <= rx_drop_d;
`ifdef UART_FRAME_TIMEOUT_EN
            gap_q       <= gap_d;
`endif
        end
    end

    // Payload storage needs no reset; it is only read after being written.
    always_ff @(posedge clk) begin
        if (pay_we) pay_q[idx_q[IdxW-1:0]] <= rx_data;
    end

    assign out_valid = (state_q == StDrain);
    assign out_data  = out_valid ? pay_q[rd_idx_q[IdxW-1:0]] : 8'd0;
    assign out_last  = out_valid && (rd_idx_q == frm_len_q - 8'd1);
    assign frm_start = frm_start_q;
    assign frm_cmd   = frm_cmd_q;
    assign frm_len   = frm_len_q;
    assign frm_err   = frm_err_q;
    assign err_code  = err_code_q;
    assign rx_drop   = rx_drop_q;

endmodule

// File: tb/tb_uart_frame_parser.sv
// Directed self-checking bench for uart_frame_parser (MAX_LEN=16, TIMEOUT_CYC=100).
module tb_uart_frame_parser;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       frm_start;
    logic [7:0] frm_cmd;
    logic [7:0] frm_len;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       out_last;
    logic       frm_err;
    logic [1:0] err_code;
    logic       rx_drop;

    int n_checks = 0;
    int n_errs   = 0;
    int n_start  = 0;
    int n_ferr   = 0;
    int n_drop   = 0;

    logic [8:0] got_q [$];
    logic [8:0] exp_q [$];
    logic [7:0] frame [$];

    uart_frame_parser #(
        .MAX_LEN     (16),
        .TIMEOUT_CYC (100)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_data   (rx_data),
        .rx_done   (rx_done),
        .frm_start (frm_start),
        .frm_cmd   (frm_cmd),
        .frm_len   (frm_len),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .frm_err   (frm_err),
        .err_code  (err_code),
        .rx_drop   (rx_drop)
    );

    always #5 clk = ~clk;

    // Stream capture and pulse counting, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && out_ready) got_q.push_back({out_last, out_data});
            if (frm_start) n_start++;
            if (frm_err)   n_ferr++;
            if (rx_drop)   n_drop++;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1;
        rx_data = b;
        rx_done = 1'b1;
        @(posedge clk); #1;
        rx_done = 1'b0;
    endtask

    task automatic send_frame();
        foreach (frame[i]) send_byte(frame[i]);
    endtask

    task automatic clear_obs();
        got_q.delete();
        exp_q.delete();
        n_start = 0;
        n_ferr  = 0;
        n_drop  = 0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_stream(input string tag);
        check_eq({tag, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            check_eq(tag, (i < got_q.size()) ? 32'(got_q[i]) : 32'hDEAD, 32'(exp_q[i]));
    endtask

    initial begin
        rst_n     = 1'b0;
        rx_data   = 8'd0;
        rx_done   = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle_cycles(1);

        check_eq("rst_frm_start", frm_start, 0);
        check_eq("rst_frm_cmd",   frm_cmd,   0);
        check_eq("rst_frm_len",   frm_len,   0);
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_out_data",  out_data,  0);
        check_eq("rst_out_last",  out_last,  0);
        check_eq("rst_frm_err",   frm_err,   0);
        check_eq("rst_err_code",  err_code,  0);
        check_eq("rst_rx_drop",   rx_drop,   0);

        // Basic frame, consumer always ready.
        clear_obs();
        frame = '{8'hA5, 8'h5A, 8'h10, 8'h03, 8'h11, 8'h22, 8'h33, 8'h79};
        send_frame();
        check_eq("t1_frm_start", frm_start, 1);
        check_eq("t1_frm_cmd",   frm_cmd,   8'h10);
        check_eq("t1_frm_len",   frm_len,   8'h03);
        check_eq("t1_out_valid", out_valid, 1);
        check_eq("t1_out_data0", out_data,  8'h11);
        idle_cycles(5);
        exp_q = '{9'h011, 9'h022, 9'h133};
        check_stream("t1_stream");
        check_eq("t1_n_start",   n_start,   1);
        check_eq("t1_n_err",     n_ferr,    0);
        check_eq("t1_valid_end", out_valid, 0);

        // Stalled consumer, byte dropped during drain, then toggled ready.
        clear_obs();
        out_ready = 1'b0;
        send_frame();
        for (int i = 0; i < 5; i++) begin
            check_eq("t2_stall_valid", out_valid, 1);
            check_eq("t2_stall_data",  out_data,  8'h11);
            idle_cycles(1);
        end
        send_byte(8'hA5);
        check_eq("t2_rx_drop",     rx_drop,   1);
        check_eq("t2_hold_after",  out_data,  8'h11);
        check_eq("t2_valid_after", out_valid, 1);
        for (int i = 0; i < 40 && got_q.size() < 3; i++) begin
            out_ready = ~out_ready;
            idle_cycles(1);
        end
        out_ready = 1'b1;
        idle_cycles(3);
        exp_q = '{9'h011, 9'h022, 9'h133};
        check_stream("t2_stream");
        check_eq("t2_n_drop",    n_drop,    1);
        check_eq("t2_valid_end", out_valid, 0);

        // Bad checksum, then a good frame.
        clear_obs();
        frame = '{8'hA5, 8'h5A, 8'h01, 8'h02, 8'hAA, 8'hBB, 8'h00};
        send_frame();
        check_eq("t3_frm_err",   frm_err,   1);
        check_eq("t3_err_code",  err_code,  2);
        check_eq("t3_out_valid", out_valid, 0);
        idle_cycles(3);
        check_eq("t3_n_start",   n_start,       0);
        check_eq("t3_no_stream", got_q.size(),  0);
        frame = '{8'hA5, 8'h5A, 8'h20, 8'h01, 8'h44, 8'h65};
        send_frame();
        check_eq("t3b_frm_start", frm_start, 1);
        check_eq("t3b_frm_cmd",   frm_cmd,   8'h20);
        check_eq("t3b_frm_len",   frm_len,   8'h01);
        idle_cycles(3);
        exp_q = '{9'h144};
        check_stream("t3b_stream");
        check_eq("t3b_err_held", err_code, 2);

        // LEN above MAX_LEN; trailing bytes ignored.
        clear_obs();
        frame = '{8'hA5, 8'h5A, 8'h07, 8'h11};
        send_frame();
        check_eq("t4_frm_err",  frm_err,  1);
        check_eq("t4_err_code", err_code, 1);
        frame = '{8'h5A, 8'h07, 8'h00, 8'h07};
        send_frame();
        idle_cycles(2);
        check_eq("t4_n_start", n_start, 0);
        check_eq("t4_n_err",   n_ferr,  1);

        // Header resync and zero-length frame.
        clear_obs();
        frame = '{8'hA5, 8'hA5, 8'h5A, 8'h02, 8'h00, 8'h02};
        send_frame();
        check_eq("t5_frm_start", frm_start, 1);
        check_eq("t5_frm_cmd",   frm_cmd,   8'h02);
        check_eq("t5_frm_len",   frm_len,   8'h00);
        check_eq("t5_out_valid", out_valid, 0);
        idle_cycles(3);
        check_eq("t5_no_stream", got_q.size(), 0);

        // LEN equal to MAX_LEN is accepted.
        clear_obs();
        frame = '{8'hA5, 8'h5A, 8'h30, 8'h10};
        for (int i = 0; i < 16; i++) frame.push_back(8'(i));
        frame.push_back(8'hB8);
        send_frame();
        check_eq("t6_frm_start", frm_start, 1);
        check_eq("t6_frm_len",   frm_len,   8'h10);
        idle_cycles(20);
        for (int i = 0; i < 16; i++) exp_q.push_back({(i == 15), 8'(i)});
        check_stream("t6_stream");

        // Checksum wraps modulo 256.
        clear_obs();
        frame = '{8'hA5, 8'h5A, 8'hFF, 8'h02, 8'h80, 8'h81, 8'h02};
        send_frame();
        check_eq("t7_frm_start", frm_start, 1);
        check_eq("t7_frm_cmd",   frm_cmd,   8'hFF);
        idle_cycles(4);
        exp_q = '{9'h080, 9'h181};
        check_stream("t7_stream");
        check_eq("t7_n_err", n_ferr, 0);

        // Asynchronous reset in the middle of a drain abandons the stream.
        clear_obs();
        out_ready = 1'b0;
        frame = '{8'hA5, 8'h5A, 8'h10, 8'h03, 8'h11, 8'h22, 8'h33, 8'h79};
        send_frame();
        check_eq("t8_pre_valid", out_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("t8_rst_valid", out_valid, 0);
        check_eq("t8_rst_cmd",   frm_cmd,   0);
        @(posedge clk); #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        idle_cycles(2);
        check_eq("t8_idle_valid", out_valid, 0);

`ifdef UART_FRAME_TIMEOUT_EN
        clear_obs();
        frame = '{8'hA5, 8'h5A, 8'h03};
        send_frame();
        for (int i = 0; i < 150 && n_ferr == 0; i++) idle_cycles(1);
        check_eq("t9_timeout_err", n_ferr,   1);
        check_eq("t9_err_code",    err_code, 3);
        frame = '{8'hA5, 8'h5A, 8'h20, 8'h01, 8'h44, 8'h65};
        send_frame();
        check_eq("t9_recover", frm_start, 1);
`endif

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
